// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream packet arbiter: N slave ports share one registered master port,
// the grant is held for a whole packet and re-arbitrated in one IDLE cycle between packets.
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 4,
    localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_data,
    input  logic [NUM_PORTS-1:0]            s_axis_valid,
    input  logic [NUM_PORTS-1:0]            s_axis_last,
    output logic [NUM_PORTS-1:0]            s_axis_ready,
    output logic [DATA_WIDTH-1:0]           m_axis_data,
    output logic                            m_axis_valid,
    output logic                            m_axis_last,
    input  logic                            m_axis_ready,
    output logic [IDW-1:0]                  grant_id,
    output logic                            busy
);

    typedef enum logic {IDLE, PASS} state_e;

    state_e                state_q;
    logic [IDW-1:0]        grant_q, last_grant_q, grant_d;
    logic [DATA_WIDTH-1:0] mdata_q;
    logic                  mvalid_q, mlast_q;
    logic                  found;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid, sel_last;
    logic                  slot_free, xfer;

    // Scan from last_grant+1 with wrap; first valid port wins.
    always_comb begin
        grant_d = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            int idx;
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && s_axis_valid[IDW'(idx)]) begin
                found   = 1'b1;
                grant_d = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_data  = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_valid[i];
                sel_last  = s_axis_last[i];
            end
        end
    end

    assign slot_free = !mvalid_q || m_axis_ready;
    assign xfer      = (state_q == PASS) && slot_free && sel_valid;

    always_comb begin
        s_axis_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            s_axis_ready[i] = (state_q == PASS) && slot_free && (grant_q == IDW'(i));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NUM_PORTS - 1);
            mdata_q      <= '0;
            mvalid_q     <= 1'b0;
            mlast_q      <= 1'b0;
        end else begin
            // Drain first; a load in the same cycle overrides it (no bubble).
            if (mvalid_q && m_axis_ready) mvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= grant_d;
                        state_q <= PASS;
                    end
                end
                PASS: begin
                    if (xfer) begin
                        mdata_q  <= sel_data;
                        mlast_q  <= sel_last;
                        mvalid_q <= 1'b1;
                        if (sel_last) begin
                            state_q      <= IDLE;
                            last_grant_q <= grant_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_data  = mdata_q;
    assign m_axis_valid = mvalid_q;
    assign m_axis_last  = mlast_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q == PASS);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: vector table, directed corner sequences,
// and random traffic against a queue-based packet-level reference model.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [N*DW-1:0] s_axis_data = '0;
    logic [N-1:0]  s_axis_valid = '0, s_axis_last = '0, s_axis_ready;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid, m_axis_last;
    logic          m_axis_ready = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;

    always #5 aclk = ~aclk;

    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(N)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
        .s_axis_last(s_axis_last), .s_axis_ready(s_axis_ready),
        .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
        .m_axis_last(m_axis_last), .m_axis_ready(m_axis_ready),
        .grant_id(grant_id), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]  v;
        logic [31:0]   d;
        logic [N-1:0]  l;
        logic          r;
        logic [N-1:0]  e_rdy;
        logic          e_mv;
        logic [DW-1:0] e_md;
        logic          e_ml;
        logic          e_busy;
        logic [1:0]    e_gid;
    } vec_t;
    vec_t tbl[6];

    // Reference model: a held grant, the previous winner, and an output slot queue (depth <= 1).
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;
    bit           mb;
    int           mg, ml;
    beat_t        oq[$];
    logic [N-1:0] mrdy_exp;
    logic [DW-1:0] taken[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mb = 1'b0; mg = 0; ml = N - 1;
        oq.delete();
    endtask

    task automatic model_check();
        mrdy_exp = '0;
        if (mb && (oq.size() == 0 || m_axis_ready)) mrdy_exp[mg] = 1'b1;
        chk("ready", 32'(s_axis_ready), 32'(mrdy_exp));
        chk("m_valid", 32'(m_axis_valid), 32'(oq.size() != 0));
        if (oq.size() != 0) begin
            chk("m_data", 32'(m_axis_data), 32'(oq[0].d));
            chk("m_last", 32'(m_axis_last), 32'(oq[0].l));
        end
        chk("busy", 32'(busy), 32'(mb));
        if (mb) chk("grant_id", 32'(grant_id), 32'(mg));
    endtask

    task automatic model_step();
        bit xfer;
        beat_t b;
        xfer = mb && (oq.size() == 0 || m_axis_ready) && s_axis_valid[mg];
        if (oq.size() != 0 && m_axis_ready) void'(oq.pop_front());
        if (xfer) begin
            b.d = s_axis_data[mg*DW +: DW];
            b.l = s_axis_last[mg];
            oq.push_back(b);
            if (b.l) begin mb = 1'b0; ml = mg; end
        end else if (!mb) begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (ml + k) % N;
                if (s_axis_valid[p]) begin mg = p; mb = 1'b1; break; end
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [31:0] d, input logic [N-1:0] l, input logic r);
        s_axis_valid = v; s_axis_data = d; s_axis_last = l; m_axis_ready = r;
    endtask

    task automatic cyc(input logic [N-1:0] v, input logic [31:0] d, input logic [N-1:0] l, input logic r);
        @(negedge aclk);
        drive(v, d, l, r);
        #1;
        model_check();
        if (m_axis_valid && m_axis_ready) taken.push_back(m_axis_data);
        model_step();
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_axis_valid), 0);
        chk("rst_m_data", 32'(m_axis_data), 0);
        chk("rst_m_last", 32'(m_axis_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_ready", 32'(s_axis_ready), 0);
        model_reset();
        @(negedge aclk);
        drive('0, '0, '0, 1'b0);
        aresetn = 1'b1;
        taken.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] v, l;
        logic [31:0]  d;
        logic         r;
        logic [1:0]   gseq[$];
        logic         pb;
        int           cnt[N];
        logic [1:0]   exp_g[5];

        tbl[0] = '{4'b0101, 32'h0033_0011, 4'b0101, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};
        tbl[1] = '{4'b0101, 32'h0033_0011, 4'b0101, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0};
        tbl[2] = '{4'b0100, 32'h0033_0011, 4'b0100, 1'b1, 4'b0000, 1'b1, 8'h11, 1'b1, 1'b0, 2'd0};
        tbl[3] = '{4'b0100, 32'h0033_0011, 4'b0100, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2};
        tbl[4] = '{4'b0000, 32'h0033_0011, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'h33, 1'b1, 1'b0, 2'd0};
        tbl[5] = '{4'b0000, 32'h0033_0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0};

        model_reset();
        do_reset();

        // Two single-beat packets from ports 0 and 2.
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(s_axis_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_mvalid", i), 32'(m_axis_valid), 32'(tbl[i].e_mv));
            if (tbl[i].e_mv) begin
                chk($sformatf("tbl%0d_mdata", i), 32'(m_axis_data), 32'(tbl[i].e_md));
                chk($sformatf("tbl%0d_mlast", i), 32'(m_axis_last), 32'(tbl[i].e_ml));
            end
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].e_busy) chk($sformatf("tbl%0d_gid", i), 32'(grant_id), 32'(tbl[i].e_gid));
        end

        // All ports streaming 2-beat packets: strict rotation.
        do_reset();
        for (int p = 0; p < N; p++) cnt[p] = 0;
        pb = 1'b0;
        for (int c = 0; c < 16; c++) begin
            l = '0; d = '0;
            for (int p = 0; p < N; p++) begin
                l[p] = (cnt[p] == 1);
                d[p*DW +: DW] = 8'(p * 16 + cnt[p]);
            end
            cyc(4'hF, d, l, 1'b1);
            if (busy && !pb) gseq.push_back(grant_id);
            pb = busy;
            for (int p = 0; p < N; p++) if (mrdy_exp[p]) cnt[p] = (cnt[p] + 1) % 2;
        end
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        chk("rr_grants_seen", 32'(gseq.size() >= 5), 1);
        for (int k = 0; k < 5 && k < gseq.size(); k++)
            chk($sformatf("rr_grant%0d", k), 32'(gseq[k]), 32'(exp_g[k]));

        // Port 1 three-beat packet with downstream stall.
        do_reset();
        cyc(4'b0010, 32'h0000_A100, 4'b0000, 1'b1);
        cyc(4'b0010, 32'h0000_A100, 4'b0000, 1'b0);
        for (int c = 0; c < 3; c++) begin
            cyc(4'b0010, 32'h0000_A200, 4'b0000, 1'b0);
            chk("stall_data", 32'(m_axis_data), 32'hA1);
            chk("stall_ready1", 32'(s_axis_ready[1]), 0);
        end
        cyc(4'b0010, 32'h0000_A200, 4'b0000, 1'b1);
        cyc(4'b0010, 32'h0000_A300, 4'b0010, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        chk("stall_beats", 32'(taken.size()), 3);
        if (taken.size() == 3) begin
            chk("stall_b0", 32'(taken[0]), 32'hA1);
            chk("stall_b1", 32'(taken[1]), 32'hA2);
            chk("stall_b2", 32'(taken[2]), 32'hA3);
        end

        // Port 3 pauses mid-packet while port 0 waits.
        do_reset();
        cyc(4'b1000, 32'hB100_00C0, 4'b0001, 1'b1);
        cyc(4'b1001, 32'hB100_00C0, 4'b0001, 1'b1);
        for (int c = 0; c < 2; c++) begin
            cyc(4'b0001, 32'hB200_00C0, 4'b0001, 1'b1);
            chk("hold_busy", 32'(busy), 1);
            chk("hold_gid", 32'(grant_id), 3);
            chk("hold_ready0", 32'(s_axis_ready[0]), 0);
        end
        cyc(4'b1001, 32'hB200_00C0, 4'b1001, 1'b1);
        cyc(4'b0001, 32'hB200_00C0, 4'b0001, 1'b1);
        cyc(4'b0001, 32'hB200_00C0, 4'b0001, 1'b1);
        chk("hold_then_port0", 32'(grant_id), 0);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);

        // Reset in the middle of a 4-beat packet from port 1.
        do_reset();
        cyc(4'b0010, 32'h0000_D100, 4'b0000, 1'b1);
        cyc(4'b0010, 32'h0000_D100, 4'b0000, 1'b0);
        @(negedge aclk);
        chk("pre_rst_mvalid", 32'(m_axis_valid), 1);
        drive(4'b0011, 32'h0000_D2E0, 4'b0001, 1'b0);
        aresetn = 1'b0;
        #1;
        chk("midrst_mvalid", 32'(m_axis_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(s_axis_ready), 0);
        model_reset();
        @(negedge aclk);
        drive('0, '0, '0, 1'b0);
        aresetn = 1'b1;
        cyc(4'b0011, 32'h0000_D2E0, 4'b0001, 1'b1);
        cyc(4'b0011, 32'h0000_D2E0, 4'b0001, 1'b1);
        chk("postrst_gid", 32'(grant_id), 0);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b1);

        // Port 2 alone, back-to-back single-beat packets.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            cyc(4'b0100, {8'h0, 8'(8'h50 + c), 16'h0}, 4'b0100, 1'b1);
            if (busy) chk("solo_gid", 32'(grant_id), 2);
        end
        chk("solo_beats", 32'(taken.size()), 4);

        // Random traffic, with one reset mid-run.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            v = 4'($urandom);
            d = $urandom;
            for (int p = 0; p < N; p++) l[p] = ($urandom_range(2) == 0);
            r = ($urandom_range(3) != 0);
            cyc(v, d, l, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
